// File: rtl/uart_flit_rx_pkg.sv
// Shared types for the UART flit link.
// Flit/checksum types, UART FSM states and the flit checksum.
package uart_flit_rx_pkg;

  localparam int unsigned CPU_CLK_HZ  = 100_000_000;
  localparam int unsigned UART_CLK_HZ = 115_200;

  typedef logic [127:0] flit_t;
  typedef logic [15:0]  checksum_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

  // Sum of the seven big-endian words above the checksum field
  function automatic checksum_t flit_checksum(flit_t f);
    checksum_t s;
    s = '0;
    for (int i = 0; i < 7; i++) begin
      s = s + f[127-16*i -: 16];
    end
    return s;
  endfunction

endpackage

// File: rtl/uart_flit_rx_if.sv
// Valid/ready flit channel from the UART receiver to the router.
interface uart_flit_rx_if;
  import uart_flit_rx_pkg::*;

  flit_t flit_o;
  logic  flit_valid;
  logic  flit_ready;

  modport master (
    output flit_o,
    output flit_valid,
    input  flit_ready
  );

  modport slave (
    input  flit_o,
    input  flit_valid,
    output flit_ready
  );

endinterface

// File: rtl/uart_flit_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, bit timer and byte FSM.
// byte_done / framing_err are single-cycle registered pulses.
module uart_rx_byte
  import uart_flit_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       framing_err,
  output logic       rx_idle
);

  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);

  logic           rx_s1_q, rx_s2_q;
  uart_rx_state_t state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           done_q, done_d;
  logic           ferr_q, ferr_d;
  logic           expire;

  assign expire = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = expire ? cnt_q : cnt_q - 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          state_d = RX_START;
          cnt_d   = HALF;
        end
      end
      RX_START: begin
        if (expire) begin
          if (!rx_s2_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (expire) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (expire) begin
          state_d = RX_IDLE;
          done_d  = rx_s2_q;
          ferr_d  = !rx_s2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data   = shift_q;
  assign byte_done   = done_q;
  assign framing_err = ferr_q;
  assign rx_idle     = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_flit_rx.sv
// UART flit receiver: assembles 16 bytes into a flit, checks it,
// and offers good flits on a single-entry valid/ready register.
module uart_flit_rx
  import uart_flit_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV      = CPU_CLK_HZ / UART_CLK_HZ,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_flit_rx_if.master flit_if,
  output logic           err_framing,
  output logic           err_checksum,
  output logic           err_overflow,
  output logic           err_timeout
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_BITS * CLK_DIV - 1);

  logic [7:0]  byte_data;
  logic        byte_done;
  logic        framing_err;
  logic        rx_idle;

  logic [3:0]  idx_q, idx_d;
  flit_t       buf_q, buf_d;
  logic        chk_q, chk_d;
  flit_t       out_q, out_d;
  logic        valid_q, valid_d;
  logic        cerr_q, cerr_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        good;

  uart_rx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .byte_data   (byte_data),
    .byte_done   (byte_done),
    .framing_err (framing_err),
    .rx_idle     (rx_idle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      buf_q     <= '0;
      chk_q     <= 1'b0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      cerr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      chk_q     <= chk_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      cerr_q    <= cerr_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    idx_d     = idx_q;
    buf_d     = buf_q;
    chk_d     = 1'b0;
    out_d     = out_q;
    valid_d   = valid_q;
    cerr_d    = 1'b0;
    ovf_d     = 1'b0;
    tmo_d     = 1'b0;
    tmo_cnt_d = '0;
    good      = (flit_checksum(buf_q) == buf_q[15:0]);

    if (valid_q && flit_if.flit_ready) valid_d = 1'b0;

    // A held flit always wins, even on its handshake cycle
    if (chk_q) begin
      if (!good) begin
        cerr_d = 1'b1;
      end else if (valid_q) begin
        ovf_d = 1'b1;
      end else begin
        out_d   = buf_q;
        valid_d = 1'b1;
      end
    end

    unique case (1'b1)
      framing_err: begin
        idx_d = '0;
      end
      byte_done: begin
        buf_d[{~idx_q, 3'b000} +: 8] = byte_data;
        idx_d = idx_q + 4'd1;
        chk_d = (idx_q == 4'd15);
      end
      default: begin
        if (idx_q != '0 && rx_idle) begin
          if (tmo_cnt_q == TMO_LAST) begin
            tmo_d = 1'b1;
            idx_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
          end
        end
      end
    endcase
  end

  assign flit_if.flit_o     = out_q;
  assign flit_if.flit_valid = valid_q;
  assign err_framing        = framing_err;
  assign err_checksum       = cerr_q;
  assign err_overflow       = ovf_q;
  assign err_timeout        = tmo_q;

endmodule

// File: tb/tb_uart_flit_rx.sv
// Bench for uart_flit_rx: serial stimulus against a byte-level model.
module tb_uart_flit_rx;
  import uart_flit_rx_pkg::*;

  localparam int CLK_DIV      = 16;
  localparam int TIMEOUT_BITS = 4;

  typedef logic [7:0] bytes_t [16];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic err_framing, err_checksum, err_overflow, err_timeout;

  uart_flit_rx_if fif();

  uart_flit_rx #(
    .CLK_DIV      (CLK_DIV),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .flit_if      (fif),
    .err_framing  (err_framing),
    .err_checksum (err_checksum),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int n_acc  = 0;
  int n_vcyc = 0;
  int n_frm  = 0;
  int n_chk  = 0;
  int n_ovf  = 0;
  int n_tmo  = 0;
  flit_t got_q[$];

  always @(negedge clk) begin
    if (fif.flit_valid === 1'b1 && fif.flit_ready === 1'b1) begin
      got_q.push_back(fif.flit_o);
      n_acc++;
    end
    if (fif.flit_valid === 1'b1) n_vcyc++;
    if (err_framing === 1'b1)  n_frm++;
    if (err_checksum === 1'b1) n_chk++;
    if (err_overflow === 1'b1) n_ovf++;
    if (err_timeout === 1'b1)  n_tmo++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic flit_t pack(bytes_t b);
    flit_t f;
    f = '0;
    for (int k = 0; k < 16; k++) f = {f[119:0], b[k]};
    return f;
  endfunction

  task automatic make_good(output bytes_t b);
    int s;
    s = 0;
    for (int k = 0; k < 14; k++) b[k] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 7; w++)
      s = (s + int'(b[2*w]) * 256 + int'(b[2*w+1])) % 65536;
    b[14] = 8'(s / 256);
    b[15] = 8'(s % 256);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CLK_DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CLK_DIV) tick();
    end
    rx = stop;
    repeat (CLK_DIV) tick();
    rx = 1'b1;
  endtask

  task automatic send_flit(input bytes_t b);
    for (int k = 0; k < 16; k++) send_byte(b[k], 1'b1);
  endtask

  task automatic wait_acc(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_acc >= target) begin
        ok = 1'b1;
        break;
      end
      sample();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    sample();
    n_tot++;
    if (fif.flit_valid !== 1'b0)
      $display("FAIL reset_valid got %b want 0", fif.flit_valid);
    else n_pass++;
    n_tot++;
    if (fif.flit_o !== '0)
      $display("FAIL reset_flit got %h want 0", fif.flit_o);
    else n_pass++;
    n_tot++;
    if ({err_framing, err_checksum, err_overflow, err_timeout} !== 4'b0)
      $display("FAIL reset_errs got %b want 0000",
        {err_framing, err_checksum, err_overflow, err_timeout});
    else n_pass++;
  endtask

  task automatic test_good_flit();
    bytes_t b;
    int a0, v0, e0;
    bit ok;
    flit_t want;
    flit_t got;
    want = 128'h000102030405060708090A0B0C0D2A31;
    for (int k = 0; k < 14; k++) b[k] = 8'(k);
    b[14] = 8'h2A;
    b[15] = 8'h31;
    fif.flit_ready = 1'b1;
    a0 = n_acc; v0 = n_vcyc; e0 = n_frm + n_chk + n_ovf + n_tmo;
    send_flit(b);
    wait_acc(a0 + 1, ok);
    repeat (4) sample();
    n_tot++;
    if (!ok) $display("FAIL good_accept got none want 1 flit");
    else n_pass++;
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_tot++;
    if (got !== want) $display("FAIL good_data got %h want %h", got, want);
    else n_pass++;
    n_tot++;
    if (n_vcyc - v0 != 1)
      $display("FAIL good_pulse got %0d valid cycles want 1", n_vcyc - v0);
    else n_pass++;
    n_tot++;
    if (n_frm + n_chk + n_ovf + n_tmo - e0 != 0)
      $display("FAIL good_errs got %0d error pulses want 0",
        n_frm + n_chk + n_ovf + n_tmo - e0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bytes_t b [3];
    int a0;
    bit ok;
    flit_t got;
    fif.flit_ready = 1'b1;
    a0 = n_acc;
    for (int f = 0; f < 3; f++) make_good(b[f]);
    for (int f = 0; f < 3; f++) send_flit(b[f]);
    wait_acc(a0 + 3, ok);
    n_tot++;
    if (!ok) $display("FAIL b2b_count got %0d want 3", n_acc - a0);
    else n_pass++;
    for (int f = 0; f < 3; f++) begin
      got = (got_q.size() > 0) ? got_q.pop_front() : '0;
      n_tot++;
      if (got !== pack(b[f]))
        $display("FAIL b2b_data%0d got %h want %h", f, got, pack(b[f]));
      else n_pass++;
    end
  endtask

  task automatic test_checksum();
    bytes_t b;
    int a0, v0, c0;
    bit ok;
    flit_t got;
    fif.flit_ready = 1'b1;
    for (int k = 0; k < 14; k++) b[k] = 8'(k);
    b[14] = 8'h2A;
    b[15] = 8'h32;
    a0 = n_acc; v0 = n_vcyc; c0 = n_chk;
    send_flit(b);
    repeat (10) sample();
    n_tot++;
    if (n_chk - c0 != 1)
      $display("FAIL cksum_err got %0d pulses want 1", n_chk - c0);
    else n_pass++;
    n_tot++;
    if (n_vcyc != v0)
      $display("FAIL cksum_valid got %0d valid cycles want 0", n_vcyc - v0);
    else n_pass++;
    make_good(b);
    send_flit(b);
    wait_acc(a0 + 1, ok);
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_tot++;
    if (!ok || got !== pack(b))
      $display("FAIL cksum_next got %h want %h", got, pack(b));
    else n_pass++;
  endtask

  task automatic test_overflow();
    bytes_t a, b;
    int o0, a0;
    bit ok;
    flit_t got;
    fif.flit_ready = 1'b0;
    make_good(a);
    make_good(b);
    o0 = n_ovf; a0 = n_acc;
    send_flit(a);
    send_flit(b);
    sample();
    n_tot++;
    if (n_ovf - o0 != 1)
      $display("FAIL ovf_err got %0d pulses want 1", n_ovf - o0);
    else n_pass++;
    n_tot++;
    if (fif.flit_valid !== 1'b1)
      $display("FAIL ovf_hold_valid got %b want 1", fif.flit_valid);
    else n_pass++;
    n_tot++;
    if (fif.flit_o !== pack(a))
      $display("FAIL ovf_hold_data got %h want %h", fif.flit_o, pack(a));
    else n_pass++;
    tick();
    fif.flit_ready = 1'b1;
    sample();
    n_tot++;
    if (fif.flit_valid !== 1'b1)
      $display("FAIL ovf_hs_cycle got %b want 1", fif.flit_valid);
    else n_pass++;
    sample();
    n_tot++;
    if (fif.flit_valid !== 1'b0)
      $display("FAIL ovf_clear got %b want 0", fif.flit_valid);
    else n_pass++;
    wait_acc(a0 + 1, ok);
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_tot++;
    if (!ok || got !== pack(a) || n_acc - a0 != 1)
      $display("FAIL ovf_accept got %h (%0d) want %h (1)",
        got, n_acc - a0, pack(a));
    else n_pass++;
  endtask

  task automatic test_framing();
    bytes_t g;
    int f0, c0, a0;
    bit ok;
    flit_t got;
    fif.flit_ready = 1'b1;
    make_good(g);
    f0 = n_frm; c0 = n_chk; a0 = n_acc;
    for (int k = 0; k < 3; k++) send_byte(g[k], 1'b1);
    send_byte(g[3], 1'b0);
    repeat (2 * CLK_DIV) tick();
    n_tot++;
    if (n_frm - f0 != 1)
      $display("FAIL frm_err got %0d pulses want 1", n_frm - f0);
    else n_pass++;
    send_flit(g);
    wait_acc(a0 + 1, ok);
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_tot++;
    if (!ok || got !== pack(g))
      $display("FAIL frm_next got %h want %h", got, pack(g));
    else n_pass++;
    n_tot++;
    if (n_chk != c0)
      $display("FAIL frm_cksum got %0d pulses want 0", n_chk - c0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bytes_t g;
    int t0, c0, a0;
    bit ok;
    flit_t got;
    fif.flit_ready = 1'b1;
    make_good(g);
    t0 = n_tmo; c0 = n_chk; a0 = n_acc;
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    repeat (TIMEOUT_BITS * CLK_DIV + 20) tick();
    n_tot++;
    if (n_tmo - t0 != 1)
      $display("FAIL tmo_err got %0d pulses want 1", n_tmo - t0);
    else n_pass++;
    send_flit(g);
    wait_acc(a0 + 1, ok);
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_tot++;
    if (!ok || got !== pack(g) || n_chk != c0)
      $display("FAIL tmo_next got %h cksum_errs %0d want %h 0",
        got, n_chk - c0, pack(g));
    else n_pass++;
    n_tot++;
    if (n_tmo - t0 != 1)
      $display("FAIL tmo_once got %0d pulses want 1", n_tmo - t0);
    else n_pass++;
  endtask

  task automatic test_glitch_reset();
    bytes_t h1, h2, h3;
    int a0, e0;
    bit ok;
    flit_t got;
    fif.flit_ready = 1'b1;
    a0 = n_acc; e0 = n_frm + n_chk + n_ovf + n_tmo;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    n_tot++;
    if (n_acc != a0 || n_frm + n_chk + n_ovf + n_tmo != e0)
      $display("FAIL glitch got %0d flits %0d errs want 0 0",
        n_acc - a0, n_frm + n_chk + n_ovf + n_tmo - e0);
    else n_pass++;
    fif.flit_ready = 1'b0;
    make_good(h1);
    make_good(h2);
    make_good(h3);
    send_flit(h1);
    for (int k = 0; k < 7; k++) send_byte(h2[k], 1'b1);
    rx = 1'b0;
    repeat (CLK_DIV) tick();
    for (int i = 0; i < 3; i++) begin
      rx = h2[7][i];
      repeat (CLK_DIV) tick();
    end
    n_tot++;
    if (fif.flit_valid !== 1'b1)
      $display("FAIL rst_pre_valid got %b want 1", fif.flit_valid);
    else n_pass++;
    rst = 1'b1;
    rx = 1'b1;
    tick();
    sample();
    n_tot++;
    if (fif.flit_valid !== 1'b0 || fif.flit_o !== '0)
      $display("FAIL rst_out got %b %h want 0 0", fif.flit_valid, fif.flit_o);
    else n_pass++;
    n_tot++;
    if ({err_framing, err_checksum, err_overflow, err_timeout} !== 4'b0)
      $display("FAIL rst_errs got %b want 0000",
        {err_framing, err_checksum, err_overflow, err_timeout});
    else n_pass++;
    tick();
    rst = 1'b0;
    fif.flit_ready = 1'b1;
    repeat (4) tick();
    a0 = n_acc; e0 = n_frm + n_chk + n_ovf + n_tmo;
    send_flit(h3);
    wait_acc(a0 + 1, ok);
    got = (got_q.size() > 0) ? got_q.pop_front() : '0;
    n_tot++;
    if (!ok || got !== pack(h3))
      $display("FAIL rst_next got %h want %h", got, pack(h3));
    else n_pass++;
    n_tot++;
    if (n_frm + n_chk + n_ovf + n_tmo != e0)
      $display("FAIL rst_next_errs got %0d want 0",
        n_frm + n_chk + n_ovf + n_tmo - e0);
    else n_pass++;
  endtask

  initial begin
    fif.flit_ready = 1'b0;
    test_reset();
    test_good_flit();
    test_back_to_back();
    test_checksum();
    test_overflow();
    test_framing();
    test_timeout();
    test_glitch_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/uart_flit_rx.md
Name: uart_flit_rx

Overview:
- Receive side of the UART flit link. Deserialises 8N1 UART bytes from the rx pin.
- Assembles 16 consecutive bytes into one 128-bit flit_t and verifies its 16-bit checksum.
- Presents good flits on a valid/ready interface to the NoC router input buffer.
- Counterpart of the flit-to-UART transmitter; sits between the board rx pin and the router.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (CPU_CLK_HZ / UART_CLK_HZ); legal range 4..65535.
- TIMEOUT_BITS, 32, idle bit-times allowed between bytes of a partial flit before it is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous UART line; idle high.
- flit_o  out  128  assembled flit (flit_t); stable while flit_valid is high.
- flit_valid  out  1  flit_o holds a checksum-good flit.
- flit_ready  in  1  consumer accepts flit_o when flit_valid && flit_ready.
- err_framing  out  1  one-cycle pulse: stop bit sampled low.
- err_checksum  out  1  one-cycle pulse: completed flit failed its checksum.
- err_overflow  out  1  one-cycle pulse: good flit dropped because flit_valid was still high.
- err_timeout  out  1  one-cycle pulse: partial flit abandoned on inter-byte timeout.

Behaviour:
- Reset:
  - All outputs 0; flit_o = 0.
  - Byte state RX_IDLE, byte index 0, synchroniser flops = 1.
  - Reset mid-frame or mid-flit discards all partial data.
- Synchroniser: rx passes through 2 flops; all logic uses the synchronised value.
- Byte FSM (uart_rx_state_t):
  - RX_IDLE: on synchronised rx = 0, load bit counter with CLK_DIV/2 and go to RX_START.
  - RX_START: when counter expires, resample. If 0, go to RX_DATA with counter = CLK_DIV. If 1, it is a glitch: return to RX_IDLE with no error.
  - RX_DATA: sample at each counter expiry and shift in LSB first; after 8 samples go to RX_STOP.
  - RX_STOP: sample at expiry. If 1, byte_done pulses for 1 cycle and the FSM returns to RX_IDLE. If 0, pulse err_framing, return to RX_IDLE, and reset the flit assembler (index 0).
  - A new start bit may be accepted on the cycle after the stop sample, so back-to-back bytes are supported.
- Flit assembler:
  - Byte index 0..15; byte k fills flit bits [127-8k -: 8], MSB-first (byte 0 = version/src_id high bits).
  - On byte_done with index < 15: store the byte and increment the index.
  - On byte_done with index 15: store the byte, wrap the index to 0, and run the check on the next cycle.
- Checksum:
  - Sum mod 2^16 of the seven 16-bit words flit[127:16], big-endian word order.
  - It must equal flit[15:0].
  - Mismatch: pulse err_checksum and discard the flit.
- Output register (single entry):
  - On a good flit with flit_valid = 0: load flit_o and set flit_valid.
  - Latency: flit_valid rises 2 cycles after byte_done of byte 15.
  - flit_valid and flit_o hold until the handshake; flit_valid clears the cycle after flit_valid && flit_ready.
  - Good flit arriving while flit_valid = 1 (including the cycle flit_ready is high): the new flit is dropped, err_overflow pulses, and the held flit is unchanged.
- Timeout:
  - While index != 0 and the FSM is in RX_IDLE, count cycles.
  - When the count reaches TIMEOUT_BITS*CLK_DIV: pulse err_timeout and set index to 0.
  - The counter clears on any start bit.
- Simultaneous events:
  - Error pulses are independent.
  - A framing error on byte 15 yields only err_framing; no checksum check runs.

Decomposition:
- types package:
  - add uart_rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_STOP}, with literals distinct from the tx enum;
  - add function flit_checksum(flit_t) returning checksum_t, shared with the transmitter.
- flit_t, checksum_t, UART_CLK_HZ and CPU_CLK_HZ are reused from the package.
- Sub-module uart_rx_byte: synchroniser, bit-timing counter and byte FSM. Outputs byte_data[7:0], byte_done and framing_err.
- The top level holds the assembler, checksum, output register and timeout.

Test Plan (CLK_DIV = 16, TIMEOUT_BITS = 4):
- Bytes 0x00..0x0D, 0x2A, 0x31 back-to-back, flit_ready = 1 -> one flit_valid pulse with flit_o = 0x000102…0D2A31; no error pulses.
- Same flit but last byte 0x32 -> err_checksum pulses once; flit_valid stays 0; the next good flit is accepted normally.
- Good flit, flit_ready = 0, then a second good flit -> err_overflow pulses; flit_o still holds the first flit; raising flit_ready clears flit_valid the cycle after the handshake.
- Byte 3 sent with stop bit 0 -> err_framing. Then a full good flit -> accepted correctly, proving the index reset.
- 5 bytes, then rx idle for 64+ cycles -> err_timeout once. A following good flit is accepted.
- rx low pulse of 4 cycles (glitch) -> no byte or error; assert rst mid-byte 7 -> all outputs 0 next cycle, and the following flit is assembled from byte 0.
